sync_fifo_rd_arbiter: RTL and testbench
=======================================

Name: sync_fifo_rd_arbiter

Overview:
- Round-robin arbiter that shares the single read port of the sync FIFO between NUM_REQ consumers.
- Grants one consumer at a time for a burst of up to MAX_BURST words.
- Drives the FIFO's rd_ready and steers the popped word to the granted consumer through a registered output stage.
- Sits between the FIFO read-side control and the consumer blocks.

Parameters:
- NUM_REQ, 4: number of requesting consumers (>=2).
- DATA_WIDTH, `DATA_WIDTH (shared FIFO defines): FIFO word width.
- MAX_BURST, 8: maximum words per grant.
- STALL_MAX, 16: consecutive empty cycles tolerated inside a burst before the grant is released.
- BURST_W, $clog2(MAX_BURST+1): width of one burst-length field.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  per-consumer read request, level-sensitive
- burst_len  in  NUM_REQ*BURST_W  packed requested burst length; field i belongs to req[i]
- rd_empty  in  1  FIFO empty flag
- fifo_rd_data  in  DATA_WIDTH  FIFO head word; valid in the same cycle as the pop
- fifo_rd_ready  out  1  read request to the FIFO
- gnt  out  NUM_REQ  one-hot grant, registered
- out_data  out  DATA_WIDTH  registered popped word
- out_valid  out  NUM_REQ  one-hot, registered; out_valid[i] marks out_data for consumer i
- burst_done  out  1  one-cycle pulse: grant released after a full burst
- stall_abort  out  1  one-cycle pulse: grant released by stall timeout or by req drop

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: gnt=0, out_valid=0, out_data=0, burst_done=0, stall_abort=0, FSM=IDLE, rr_ptr=0, counters=0. fifo_rd_ready is 0 throughout reset.
- Pop definition: pop = fifo_rd_ready & !rd_empty. This matches the FIFO's own read enable, so arbiter and FIFO always agree on the word count.
- fifo_rd_ready = (state==BURST) & req[gnt_idx] & (beat_cnt != 0). It is combinational from registered state plus live req.
- FSM states: IDLE, BURST.
- IDLE:
  - If any req bit is set, pick the first set bit scanning from rr_ptr upward, wrapping at NUM_REQ.
  - Register gnt.
  - Load beat_cnt = clamp(burst_len[i], 1, MAX_BURST); a length of 0 is treated as 1.
  - Clear stall_cnt and go to BURST.
  - No pop occurs in IDLE. This leaves one dead cycle between consecutive grants.
- BURST:
  - On each pop, decrement beat_cnt and clear stall_cnt.
  - While rd_empty=1, increment stall_cnt (saturating).
  - Pop on the final beat (beat_cnt==1): next state IDLE, pulse burst_done, gnt→0, rr_ptr = gnt_idx+1 mod NUM_REQ.
  - req[gnt_idx] drops mid-burst: no pop that cycle, next state IDLE, pulse stall_abort, rr_ptr advances as above.
  - stall_cnt reaches STALL_MAX-1 while empty: release as above with stall_abort. Words already delivered are not retried.
- Data path:
  - out_data <= fifo_rd_data on a pop; otherwise it holds its value.
  - out_valid <= gnt & {NUM_REQ{pop}}.
  - Latency: one cycle from pop to out_valid.
  - Consumers have no backpressure and must accept every out_valid beat.
- Fairness: a requester is skipped at most NUM_REQ-1 grants. A lone requester is re-granted after a single IDLE cycle.
- Requests changing while in BURST do not alter the current grant.
- Reset asserted mid-burst: all state clears immediately. Any partially transferred burst is lost; the FIFO pointers are owned by the FIFO reset.

Decomposition:
- Shared package/defines (sync_fifo_defines.vh) holds:
  - FSM state encodings ARB_IDLE, ARB_BURST.
  - Defaults for MAX_BURST and STALL_MAX next to DATA_WIDTH and FIFO_DEPTH.
- One sub-module: rr_priority_pick. It is a combinational rotate-and-priority-encode of req from rr_ptr, returning a one-hot pick and its index. It is reusable by a future write-side arbiter.

Test Plan:
- Reset then single requester: FIFO holds 3 words A,B,C; req=0001, burst_len0=4.
  - Required: gnt=0001 one cycle after req.
  - Required: out_valid[0] on A,B,C in three consecutive cycles.
  - Required: FIFO empties; stall_abort pulses after 16 empty cycles.
- Round-robin: FIFO full of 8 words, req=1111, all burst_len=2.
  - Required: grants in order 0,1,2,3.
  - Required: each grant delivers exactly 2 words, each followed by a burst_done pulse and one IDLE cycle.
- Wrap and fairness: rr_ptr=3 after serving requester 2, req=1001.
  - Required: next grant goes to 3, then to 0.
- Length clamp: burst_len=0 → 1 word popped; burst_len=15 → exactly 8 (MAX_BURST) words popped.
- Req drop mid-burst: burst_len=4, req deasserted after 2 pops.
  - Required: no third pop, stall_abort pulses, FIFO rd_addr advanced by exactly 2.
- Async reset mid-burst: reset asserted between clock edges.
  - Required: gnt, out_valid and fifo_rd_ready go to 0 immediately.
  - Required: after release, the first grant goes to requester 0 when req=1111.

Source files
------------

// File: rtl/sync_fifo_rd_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sync_fifo_rd_arbiter_pkg                                  |
// | Brief    : Shared FIFO defaults, read-arbiter FSM state encodings    |
// |            and a small index-wrapping helper.                        |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package sync_fifo_rd_arbiter_pkg;

    // FIFO-wide defaults, kept together so every FIFO-side block agrees
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_FIFO_DEPTH = 16;
    localparam int DEF_MAX_BURST  = 8;
    localparam int DEF_STALL_MAX  = 16;

    // Arbiter FSM encodings
    localparam int              ARB_STATE_W = 1;
    localparam logic [ARB_STATE_W-1:0] ARB_IDLE  = 1'b0;
    localparam logic [ARB_STATE_W-1:0] ARB_BURST = 1'b1;

    // Increment an index and wrap it back to zero at n
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage : sync_fifo_rd_arbiter_pkg
`default_nettype wire

// File: rtl/rr_priority_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rr_priority_pick                                          |
// | Brief    : Combinational round-robin pick. Scans the request vector  |
// |            upward from a start pointer (wrapping) and returns the    |
// |            first set bit as one-hot plus its index.                  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module rr_priority_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_pick,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_valid
);

    // Rotating priority scan: the first request at or after i_ptr wins
    always_comb begin
        int v_k;
        v_k     = 0;
        o_pick  = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            v_k = int'(i_ptr) + i;
            if (v_k >= NUM_REQ) begin
                v_k = v_k - NUM_REQ;
            end
            if (!o_valid && i_req[IDX_W'(v_k)]) begin
                o_valid              = 1'b1;
                o_pick[IDX_W'(v_k)]  = 1'b1;
                o_idx                = IDX_W'(v_k);
            end
        end
    end

endmodule : rr_priority_pick
`default_nettype wire

// File: rtl/sync_fifo_rd_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sync_fifo_rd_arbiter                                      |
// | Brief    : Round-robin arbiter sharing the FIFO read port between    |
// |            NUM_REQ consumers in bursts of up to MAX_BURST words,     |
// |            with a registered, per-consumer steered output stage.    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module sync_fifo_rd_arbiter
    import sync_fifo_rd_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_BURST  = DEF_MAX_BURST,
    parameter int STALL_MAX  = DEF_STALL_MAX,
    parameter int BURST_W    = $clog2(MAX_BURST + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*BURST_W-1:0] burst_len,
    input  logic                       rd_empty,
    input  logic [DATA_WIDTH-1:0]      fifo_rd_data,
    output logic                       fifo_rd_ready,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic [NUM_REQ-1:0]         out_valid,
    output logic                       burst_done,
    output logic                       stall_abort
);

    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int STALL_W = $clog2(STALL_MAX);

    localparam logic [BURST_W-1:0] c_one_beat   = BURST_W'(1);
    localparam logic [BURST_W-1:0] c_max_beats  = BURST_W'(MAX_BURST);
    localparam logic [STALL_W-1:0] c_stall_last = STALL_W'(STALL_MAX - 1);

    logic [ARB_STATE_W-1:0] r_state;
    logic [ARB_STATE_W-1:0] w_state_next;
    logic [IDX_W-1:0]       r_gnt_idx;
    logic [IDX_W-1:0]       r_rr_ptr;
    logic [BURST_W-1:0]     r_beat_cnt;
    logic [STALL_W-1:0]     r_stall_cnt;

    logic [NUM_REQ-1:0]     w_pick;
    logic [IDX_W-1:0]       w_pick_idx;
    logic                   w_any;
    logic [BURST_W-1:0]     w_len_arr [NUM_REQ];
    logic [BURST_W-1:0]     w_len_sel;
    logic [BURST_W-1:0]     w_len_clamped;
    logic                   w_pop;
    logic                   w_rel_done;
    logic                   w_rel_abort;
    logic                   w_release;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .i_req   (req),
        .i_ptr   (r_rr_ptr),
        .o_pick  (w_pick),
        .o_idx   (w_pick_idx),
        .o_valid (w_any)
    );

    // Unpack the per-requester burst length fields
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_len
        assign w_len_arr[g] = burst_len[g*BURST_W +: BURST_W];
    end

    assign w_len_sel = w_len_arr[w_pick_idx];
    assign w_release = w_rel_done | w_rel_abort;

    // Clamp the winner's requested length into 1..MAX_BURST
    always_comb begin
        w_len_clamped = w_len_sel;
        if (w_len_sel == '0) begin
            w_len_clamped = c_one_beat;
        end else if (w_len_sel > c_max_beats) begin
            w_len_clamped = c_max_beats;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: grant from IDLE, return to IDLE on any release
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ARB_IDLE:  if (w_any)     w_state_next = ARB_BURST;
            ARB_BURST: if (w_release) w_state_next = ARB_IDLE;
            default:                  w_state_next = ARB_IDLE;
        endcase
    end

    // FSM outputs: read request, pop and release causes; a dropped
    // request wins over everything so no word is popped in that cycle
    always_comb begin
        fifo_rd_ready = 1'b0;
        w_pop         = 1'b0;
        w_rel_done    = 1'b0;
        w_rel_abort   = 1'b0;
        if (r_state == ARB_BURST) begin
            fifo_rd_ready = req[r_gnt_idx] && (r_beat_cnt != '0);
            w_pop         = fifo_rd_ready && !rd_empty;
            if (!req[r_gnt_idx]) begin
                w_rel_abort = 1'b1;
            end else if (w_pop) begin
                w_rel_done  = (r_beat_cnt == c_one_beat);
            end else if (rd_empty && (r_stall_cnt == c_stall_last)) begin
                w_rel_abort = 1'b1;
            end
        end
    end

    // Grant, counters, round-robin pointer and the registered output stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt         <= '0;
            r_gnt_idx   <= '0;
            r_rr_ptr    <= '0;
            r_beat_cnt  <= '0;
            r_stall_cnt <= '0;
            out_data    <= '0;
            out_valid   <= '0;
            burst_done  <= 1'b0;
            stall_abort <= 1'b0;
        end else begin
            burst_done  <= w_rel_done;
            stall_abort <= w_rel_abort;
            out_valid   <= gnt & {NUM_REQ{w_pop}};
            if (w_pop) begin
                out_data <= fifo_rd_data;
            end
            if (r_state == ARB_IDLE) begin
                if (w_any) begin
                    gnt         <= w_pick;
                    r_gnt_idx   <= w_pick_idx;
                    r_beat_cnt  <= w_len_clamped;
                    r_stall_cnt <= '0;
                end
            end else if (w_release) begin
                gnt         <= '0;
                r_rr_ptr    <= IDX_W'(wrap_inc(int'(r_gnt_idx), NUM_REQ));
                r_beat_cnt  <= '0;
                r_stall_cnt <= '0;
            end else if (w_pop) begin
                r_beat_cnt  <= r_beat_cnt - 1'b1;
                r_stall_cnt <= '0;
            end else if (rd_empty && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

endmodule : sync_fifo_rd_arbiter
`default_nettype wire

// File: tb/tb_sync_fifo_rd_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_sync_fifo_rd_arbiter                                   |
// | Brief    : Directed bench for the FIFO read arbiter with a simple    |
// |            behavioural FIFO read side.                               |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_sync_fifo_rd_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DW      = 16;
    localparam int BW      = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ*BW-1:0] burst_len;
    logic              rd_empty;
    logic [DW-1:0]     fifo_rd_data;
    logic              fifo_rd_ready;
    logic [NUM_REQ-1:0] gnt;
    logic [DW-1:0]     out_data;
    logic [NUM_REQ-1:0] out_valid;
    logic              burst_done;
    logic              stall_abort;

    sync_fifo_rd_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_WIDTH (DW),
        .MAX_BURST  (8),
        .STALL_MAX  (16),
        .BURST_W    (BW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .burst_len     (burst_len),
        .rd_empty      (rd_empty),
        .fifo_rd_data  (fifo_rd_data),
        .fifo_rd_ready (fifo_rd_ready),
        .gnt           (gnt),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .burst_done    (burst_done),
        .stall_abort   (stall_abort)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO read side
    logic [DW-1:0] mem [0:63];
    int rd_addr = 0;
    int wr_addr = 0;

    assign rd_empty     = (rd_addr == wr_addr);
    assign fifo_rd_data = mem[rd_addr[5:0]];

    always @(posedge clk) begin
        if (fifo_rd_ready && !rd_empty) rd_addr <= rd_addr + 1;
    end

    int n_vec = 0;
    int n_bad = 0;
    int exp_idx = 0;
    int base;

    function automatic logic [DW-1:0] word_at(input int i);
        return 16'(i) * 16'h0123 + 16'h5A5A;
    endfunction

    task automatic load(input int n);
        for (int k = 0; k < n; k++) begin
            mem[wr_addr[5:0]] = word_at(wr_addr);
            wr_addr = wr_addr + 1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_beat(input string tag, input logic [3:0] who);
        chk({tag, "_ov"}, 32'(out_valid), 32'(who));
        chk({tag, "_data"}, 32'(out_data), 32'(word_at(exp_idx)));
        exp_idx++;
    endtask

    initial begin
        reset = 1'b1; req = '0; burst_len = '0;
        repeat (3) step();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_burst_done", 32'(burst_done), 0);
        chk("rst_stall_abort", 32'(stall_abort), 0);
        chk("rst_rd_ready", 32'(fifo_rd_ready), 0);

        // Single requester, 3 words available, burst of 4 then stall timeout
        load(3);
        reset = 1'b0;
        step();
        req = 4'b0001; burst_len = 16'h0004;
        step();
        chk("t1_gnt", 32'(gnt), 32'h1);
        chk("t1_rd_ready", 32'(fifo_rd_ready), 1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk_beat("t1_beat", 4'b0001);
        end
        for (int i = 1; i <= 15; i++) begin
            step();
            chk("t1_no_abort_yet", 32'(stall_abort), 0);
            if (i == 1) chk("t1_ov_idle", 32'(out_valid), 0);
        end
        step();
        chk("t1_stall_abort", 32'(stall_abort), 1);
        chk("t1_gnt_released", 32'(gnt), 0);
        chk("t1_popped", 32'(rd_addr), 3);
        req = '0;
        step();
        chk("t1_abort_pulse", 32'(stall_abort), 0);

        // Round robin across all four, two words each
        reset = 1'b1;
        step();
        reset = 1'b0;
        load(8); req = 4'b1111; burst_len = 16'h2222;
        for (int r = 0; r < 4; r++) begin
            step();
            chk("t2_gnt", 32'(gnt), 32'(1 << r));
            step();
            chk_beat("t2_b0", 4'(1 << r));
            chk("t2_no_done", 32'(burst_done), 0);
            step();
            chk_beat("t2_b1", 4'(1 << r));
            chk("t2_done", 32'(burst_done), 1);
            chk("t2_gnt_idle", 32'(gnt), 0);
            if (r == 3) req = '0;
        end
        step();
        chk("t2_done_pulse", 32'(burst_done), 0);

        // Serve requester 2, then wrap: 3 before 0
        load(3); req = 4'b0100; burst_len = 16'h1111;
        step();
        chk("t3_gnt2", 32'(gnt), 32'h4);
        step();
        chk_beat("t3_b2", 4'b0100);
        chk("t3_done2", 32'(burst_done), 1);
        req = 4'b1001;
        step();
        chk("t3_gnt3", 32'(gnt), 32'h8);
        step();
        chk_beat("t3_b3", 4'b1000);
        step();
        chk("t3_gnt0", 32'(gnt), 32'h1);
        step();
        chk_beat("t3_b0", 4'b0001);
        chk("t3_done0", 32'(burst_done), 1);
        req = '0;

        // Length clamp: 0 -> one word, 15 -> MAX_BURST words
        load(10); base = rd_addr;
        req = 4'b0010; burst_len = 16'h0000;
        step();
        chk("t4_gnt1", 32'(gnt), 32'h2);
        step();
        chk_beat("t4_len0", 4'b0010);
        chk("t4_len0_done", 32'(burst_done), 1);
        req = 4'b0100; burst_len = 16'h0F00;
        step();
        chk("t4_gnt2", 32'(gnt), 32'h4);
        for (int k = 0; k < 8; k++) begin
            step();
            chk_beat("t4_len15", 4'b0100);
            chk("t4_len15_done", 32'(burst_done), (k == 7) ? 1 : 0);
        end
        req = '0;
        step();
        chk("t4_ov_after", 32'(out_valid), 0);
        chk("t4_popped", 32'(rd_addr - base), 9);

        // Request drop after two pops of a four-word burst
        load(4); base = rd_addr;
        req = 4'b1000; burst_len = 16'h4000;
        step();
        chk("t5_gnt3", 32'(gnt), 32'h8);
        step();
        chk_beat("t5_b", 4'b1000);
        step();
        chk_beat("t5_b", 4'b1000);
        req = '0;
        #1;
        chk("t5_rd_ready_drop", 32'(fifo_rd_ready), 0);
        step();
        chk("t5_abort", 32'(stall_abort), 1);
        chk("t5_gnt_rel", 32'(gnt), 0);
        chk("t5_ov", 32'(out_valid), 0);
        chk("t5_popped", 32'(rd_addr - base), 2);
        step();
        chk("t5_abort_pulse", 32'(stall_abort), 0);

        // Move the pointer off zero, then reset in the middle of a burst
        req = 4'b0001; burst_len = 16'h0401;
        step();
        chk("t6_gnt0", 32'(gnt), 32'h1);
        step();
        chk_beat("t6_b0", 4'b0001);
        req = 4'b0100;
        step();
        chk("t6_gnt2", 32'(gnt), 32'h4);
        step();
        chk_beat("t6_b2", 4'b0100);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_gnt", 32'(gnt), 0);
        chk("t6_rst_ov", 32'(out_valid), 0);
        chk("t6_rst_rd_ready", 32'(fifo_rd_ready), 0);
        step();
        reset = 1'b0; req = 4'b1111; burst_len = 16'h1111;
        step();
        chk("t6_first_gnt", 32'(gnt), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_sync_fifo_rd_arbiter
`default_nettype wire
